// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO and idle interrupt
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'hFF200100,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReadEnable,
    input  logic        iWriteEnable,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic        oTX,
    output logic        oIRQ
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam int          CW     = AW + 1;
    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    state_t        state, state_n;
    logic [15:0]   baud, baud_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx, tx_n;
    logic          pop;
    logic          sel, full, empty, push_req, push, ovf_clr;
    logic [1:0]    offset;
    logic          unused;

    assign sel      = iAddress[31:4] == BASE_ADDR[31:4];
    assign offset   = iAddress[3:2];
    assign full     = count == CW'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign push_req = iWriteEnable && sel && offset == 2'd0 && iByteEnable[0];
    assign push     = push_req && !full;
    assign ovf_clr  = iWriteEnable && sel && offset == 2'd1 && iByteEnable[0] && iWriteData[3];
    assign oTX      = tx;
    assign oIRQ     = empty && state == IDLE;
    assign unused   = ^{iAddress[1:0], iWriteData[31:8], iByteEnable[3:1]};

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge iCLK) begin
        if (push) mem[wr_ptr] <= iWriteData[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow flag (a dropped push wins over a clear)
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
            ovf    <= (push_req && full) || (ovf && !ovf_clr);
        end
    end

    // Transmitter state register; reset forces the line idle-high immediately
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            baud  <= baud_n;
            idx   <= idx_n;
            shift <= shift_n;
            tx    <= tx_n;
        end
    end

    // Next-state logic: every bit lasts RELOAD+1 cycles; STOP chains straight into START when data waits
    always_comb begin
        state_n = state;
        baud_n  = baud != '0 ? baud - 16'd1 : '0;
        idx_n   = idx;
        shift_n = shift;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_n = START;
                baud_n  = RELOAD;
                shift_n = mem[rd_ptr];
                tx_n    = 1'b0;
            end
            START: if (baud == '0) begin
                state_n = DATA;
                baud_n  = RELOAD;
                idx_n   = '0;
                tx_n    = shift[0];
            end
            DATA: if (baud == '0) begin
                baud_n  = RELOAD;
                state_n = idx == 3'd7 ? STOP : DATA;
                idx_n   = idx + 3'd1;
                tx_n    = idx == 3'd7 ? 1'b1 : shift[idx + 3'd1];
            end
            STOP: if (baud == '0) begin
                pop     = !empty;
                state_n = empty ? IDLE : START;
                baud_n  = empty ? '0 : RELOAD;
                shift_n = empty ? shift : mem[rd_ptr];
                tx_n    = empty;
            end
            default: state_n = IDLE;
        endcase
    end

    // Side-effect-free STATUS read; everything else in the window reads as zero
    always_comb begin
        oReadData = (iReadEnable && sel && offset == 2'd1)
                  ? {15'd0, 9'(count), 4'd0, ovf, state != IDLE, empty, full} : '0;
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: table-driven register checks plus a serial-line scoreboard for uart_tx_mmio
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'hFF200100;
    localparam logic [31:0] STAT = 32'hFF200104;

    logic        clk, rst, re, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        tx, irq;
    logic        mon_en;
    logic [7:0]  q[$];
    int          n_checks, n_fail;

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .iCLK(clk), .iRST(rst), .iReadEnable(re), .iWriteEnable(we),
        .iByteEnable(be), .iAddress(addr), .iWriteData(wdata),
        .oReadData(rdata), .oTX(tx), .oIRQ(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; we = 1'b1;
        @(negedge clk);
        we = 1'b0; addr = '0; be = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic r, output logic [31:0] d);
        addr = a; re = r;
        #1;
        d = rdata;
        re = 1'b0; addr = '0;
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(STAT, 1'b1, d);
        check(name, 80'(d), 80'(exp));
    endtask

    // Samples nf whole frames cycle by cycle and compares against the ideal 8N1 waveform
    task automatic check_wave(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input int nf, input int exp_lat);
        int lat = 0;
        logic [79:0] act = '0;
        logic [79:0] exp = '0;
        while (tx !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 80'(lat), 80'(exp_lat));
        for (int j = 0; j < nf * 40; j++) begin
            int k = (j % 40) / 4;
            logic [7:0] b = j < 40 ? b0 : b1;
            exp[j] = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[3'(k - 1)];
            act[j] = tx;
            @(negedge clk);
        end
        check(name, act, exp);
        check({name, "_irq"}, 80'(irq), 80'(1));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((q.size() != 0 || irq !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 80'(n < budget), 80'(1));
        repeat (2) @(negedge clk);
    endtask

    // Receiver: detects a start bit, samples mid-bit, pops the expected byte from the scoreboard
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                check("rx_stop", 80'(tx), 80'(1));
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got frame %h expected none", b);
                end else begin
                    check("rx_byte", 80'(b), 80'(q.pop_front()));
                end
            end
        end
    end

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic [31:0] exp;
    } rd_vec_t;

    initial begin
        rd_vec_t     vt[9];
        logic [31:0] d;
        int          zeros;
        n_checks = 0; n_fail = 0; mon_en = 1'b1;
        rst = 1'b1; re = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;

        vt[0] = '{1'b1, 32'hFF200104, 32'h00000002};
        vt[1] = '{1'b1, 32'hFF200107, 32'h00000002};
        vt[2] = '{1'b1, 32'hFF200108, 32'h00000000};
        vt[3] = '{1'b1, 32'hFF200100, 32'h00000000};
        vt[4] = '{1'b1, 32'hFF20010C, 32'h00000000};
        vt[5] = '{1'b0, 32'hFF200104, 32'h00000000};
        vt[6] = '{1'b1, 32'hFF200114, 32'h00000000};
        vt[7] = '{1'b1, 32'hFF200004, 32'h00000000};
        vt[8] = '{1'b1, 32'h7F200104, 32'h00000000};

        repeat (3) @(negedge clk);
        check("rst_tx", 80'(tx), 80'(1));
        check("rst_irq", 80'(irq), 80'(1));
        check_status("rst_status", 32'h2);
        bus_read(STAT, 1'b0, d);
        check("rst_noread", 80'(d), 80'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) begin
            bus_read(vt[i].a, vt[i].r, d);
            check($sformatf("read_vec%0d", i), 80'(d), 80'(vt[i].exp));
            @(negedge clk);
        end

        q.push_back(8'h55);
        bus_write(BASE, 32'h00000055, 4'b0001);
        check_wave("frame55", 8'h55, 8'h00, 1, 1);
        wait_idle("frame55", 100);

        q.push_back(8'hA1);
        q.push_back(8'h3C);
        bus_write(BASE, 32'h000000A1, 4'b0001);
        bus_write(BASE, 32'h0000003C, 4'b0001);
        check_wave("b2b", 8'hA1, 8'h3C, 2, 0);
        wait_idle("b2b", 100);

        for (int i = 0; i < 6; i++) begin
            if (i < 5) q.push_back(8'h10 + 8'(i));
            addr = BASE; wdata = 32'(8'h10 + 8'(i)); be = 4'b0001; we = 1'b1;
            @(negedge clk);
        end
        we = 1'b0; addr = '0; be = '0;
        check_status("ovf_status", 32'h0000040D);
        bus_write(STAT, 32'h00000008, 4'b0010);
        check_status("ovf_keep", 32'h0000040D);
        bus_write(STAT, 32'h00000008, 4'b0001);
        check_status("ovf_clear", 32'h00000405);
        wait_idle("ovf", 400);

        bus_write(BASE, 32'h00000077, 4'b0010);
        check_status("be_nopush", 32'h00000002);
        bus_write(32'hFF200110, 32'h00000042, 4'b0001);
        check_status("outside_nopush", 32'h00000002);
        repeat (60) @(negedge clk);
        check("be_idle_tx", 80'(tx), 80'(1));

        mon_en = 1'b0;
        bus_write(BASE, 32'h00000000, 4'b0001);
        bus_write(BASE, 32'h00000000, 4'b0001);
        repeat (14) @(negedge clk);
        check("pre_rst_tx", 80'(tx), 80'(0));
        #2 rst = 1'b1;
        #1 check("rst_async_tx", 80'(tx), 80'(1));
        check_status("rst_mid_status", 32'h2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_status("post_rst_status", 32'h2);
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        check("post_rst_silent", 80'(zeros), 80'(0));
        check("post_rst_irq", 80'(irq), 80'(1));
        mon_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
